cube_window_acc: RTL

Downstream consumer of the `cube` stage. It accepts the 32-bit cube results as a valid/ready stream and sums them over a fixed window of `LEN` samples. It emits a saturating wide sum, a sample count and an overflow flag through a valid/ready output port. A `flush` input closes a partial window early. It sits between the `cube` datapath and the reporting logic.

---
 rtl/cube_pkg.sv | 12 +
 rtl/cube_window_acc_if.sv | 28 ++
 rtl/cube_window_acc_sat_add.sv | 20 ++
 rtl/cube_window_acc.sv | 109 ++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types and default widths for the cube datapath and its downstream stages.
package cube_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } cwa_state_e;

  localparam int CUBE_DATA_W = 32;
  localparam int CUBE_SUM_W  = 48;

endpackage

// File: rtl/cube_window_acc_if.sv
// Valid/ready sample input plus windowed-sum output bundle of cube_window_acc.
interface cube_window_acc_if
  import cube_pkg::*;
#(
  parameter int DATA_W = CUBE_DATA_W,
  parameter int SUM_W  = CUBE_SUM_W,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/cube_window_acc_sat_add.sv
// Unsigned saturating adder: wide accumulator plus zero-extended narrow sample.
module sat_add #(
  parameter int SUM_W  = 48,
  parameter int DATA_W = 32
) (
  input  logic [SUM_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  sum,
  output logic              sat
);
  localparam int PAD = SUM_W + 1 - DATA_W;

  logic [SUM_W:0] wide;

  always_comb begin
    wide = {1'b0, a} + {{PAD{1'b0}}, b};
    sat  = wide[SUM_W];
    sum  = sat ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
  end
endmodule

// File: rtl/cube_window_acc.sv
// Sums LEN cube results per window (or fewer on flush) and holds the saturated
// sum, count and overflow flag until the consumer takes them.
module cube_window_acc
  import cube_pkg::*;
#(
  parameter int DATA_W = CUBE_DATA_W,
  parameter int SUM_W  = CUBE_SUM_W,
  parameter int LEN    = 4,
  parameter int CNT_W  = $clog2(LEN + 1)
) (
  input logic              clock,
  input logic              reset,
  cube_window_acc_if.slave bus
);
  cwa_state_e       state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             close;
  logic [SUM_W-1:0] add_sum;
  logic             add_sat;
  logic [SUM_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx;

  sat_add #(.SUM_W(SUM_W), .DATA_W(DATA_W)) u_sat_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    accept = bus.in_valid && rdy_q;
    acc_nx = accept ? add_sum : acc_q;
    cnt_nx = cnt_q + CNT_W'(accept);
    ovf_nx = ovf_q | (accept & add_sat);
    // A flush with nothing accumulated must not emit an empty window.
    close  = (accept && (cnt_q == CNT_W'(LEN - 1))) ||
             (bus.flush && ((cnt_q != '0) || accept));

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      ACC: begin
        if (close) begin
          out_sum_d   = acc_nx;
          out_count_d = cnt_nx;
          out_ovf_d   = ovf_nx;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = HOLD;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          ovf_d = ovf_nx;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase

    // Registered ready keeps out_ready off any combinational path to in_ready.
    rdy_d = (state_d == ACC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ACC;
      rdy_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
